// File: rtl/demux_1to2.sv
// ---------------------------------------------------------------------------
// demux_1to2
//
// Registered 1-to-2 demultiplexer. A WIDTH-bit word presented with en=1 is
// steered to y0 (s=0) or y1 (s=1) on the next rising clk edge; the other
// output is forced to zero. Each path has a one-cycle valid flag and a
// saturating count of the words routed to it. All outputs come straight
// from flops, so there is no combinational path from input to output.
//
// Parameters:
//   WIDTH  - data width of d, y0, y1
//   CNT_W  - width of each routed-word counter
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset, clears every output
//   d       in   WIDTH  data word to route
//   s       in   1      select: 0 -> y0, 1 -> y1
//   en      in   1      qualifies d/s; nothing is consumed when low
//   y0      out  WIDTH  registered output 0 (zero when not selected)
//   y1      out  WIDTH  registered output 1 (zero when not selected)
//   y0_vld  out  1      y0 carries a word routed in the previous cycle
//   y1_vld  out  1      y1 carries a word routed in the previous cycle
//   cnt0    out  CNT_W  saturating count of words routed to y0
//   cnt1    out  CNT_W  saturating count of words routed to y1
// ---------------------------------------------------------------------------
module demux_1to2 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             en,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic             y0_vld,
  output logic             y1_vld,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [WIDTH-1:0] y0_q, y0_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic             y0_vld_q, y0_vld_d;
  logic             y1_vld_q, y1_vld_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // One-hot transfer strobes for the two paths. Both are low when en=0,
  // which is what clears the data/valid registers on idle cycles.
  logic take0;
  logic take1;

  // Decode which path (if any) receives this cycle's word.
  always_comb begin
    take0 = en & ~s;
    take1 = en &  s;
  end

  // Next-state for data, valid flags and counters. The unselected output is
  // driven to zero rather than held so a consumer never sees a stale word.
  // A zero data word is still a transfer: valid and count depend only on
  // the strobes, never on the value of d. Counters stick at all-ones.
  always_comb begin
    y0_d     = '0;
    y1_d     = '0;
    y0_vld_d = 1'b0;
    y1_vld_d = 1'b0;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;

    if (take0) begin
      y0_d     = d;
      y0_vld_d = 1'b1;
      if (cnt0_q != {CNT_W{1'b1}}) begin
        cnt0_d = cnt0_q + CNT_W'(1);
      end
    end

    if (take1) begin
      y1_d     = d;
      y1_vld_d = 1'b1;
      if (cnt1_q != {CNT_W{1'b1}}) begin
        cnt1_d = cnt1_q + CNT_W'(1);
      end
    end
  end

  // State register. Reset wins over everything, so a word presented on a
  // reset edge is dropped and never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      y0_q     <= '0;
      y1_q     <= '0;
      y0_vld_q <= 1'b0;
      y1_vld_q <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      y0_vld_q <= y0_vld_d;
      y1_vld_q <= y1_vld_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign y0     = y0_q;
  assign y1     = y1_q;
  assign y0_vld = y0_vld_q;
  assign y1_vld = y1_vld_q;
  assign cnt0   = cnt0_q;
  assign cnt1   = cnt1_q;

endmodule

// File: tb/tb_demux_1to2.sv
// ---------------------------------------------------------------------------
// tb_demux_1to2
//
// Drives two demux_1to2 instances from the same control inputs:
//   dut_a : WIDTH=8, CNT_W=8  (wide data, plain counting)
//   dut_b : WIDTH=1, CNT_W=2  (single-bit data, counters saturate at 3)
// dut_b sees bit 0 of the data word. Each vector row holds the inputs for one
// edge and the hand-computed outputs expected just after that edge.
// ---------------------------------------------------------------------------
module tb_demux_1to2;

  logic       clk;
  logic       rst;
  logic       en;
  logic       s;
  logic [7:0] d;
  logic       d_b;

  logic [7:0] a_y0, a_y1, a_cnt0, a_cnt1;
  logic       a_v0, a_v1;
  logic       b_y0, b_y1, b_v0, b_v1;
  logic [1:0] b_cnt0, b_cnt1;

  int numChecks;
  int numFails;

  typedef struct {
    logic       rst;
    logic       en;
    logic       s;
    logic [7:0] d;
    logic [7:0] y0;
    logic [7:0] y1;
    logic       v0;
    logic       v1;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] bc0;
    logic [1:0] bc1;
  } vec_t;

  vec_t vecs[$];

  assign d_b = d[0];

  demux_1to2 #(.WIDTH(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .d(d), .s(s), .en(en),
    .y0(a_y0), .y1(a_y1), .y0_vld(a_v0), .y1_vld(a_v1),
    .cnt0(a_cnt0), .cnt1(a_cnt1)
  );

  demux_1to2 #(.WIDTH(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .d(d_b), .s(s), .en(en),
    .y0(b_y0), .y1(b_y1), .y0_vld(b_v0), .y1_vld(b_v1),
    .cnt0(b_cnt0), .cnt1(b_cnt1)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one field and log a FAIL line on mismatch.
  task automatic checkField(input string tag, input int row,
                            input logic [7:0] got, input logic [7:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("[TB] FAIL row %0d %s: got %h expected %h", row, tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, then wait for the rising edge and
  // settle briefly so outputs are sampled away from the active edge.
  task automatic applyStimulus(input logic r, input logic e, input logic sel,
                               input logic [7:0] data);
    @(negedge clk);
    rst = r;
    en  = e;
    s   = sel;
    d   = data;
    @(posedge clk);
    #1;
  endtask

  // Check every output of both instances against one expectation record.
  task automatic checkOutput(input int row, input vec_t v);
    checkField("a.y0",   row, a_y0,         v.y0);
    checkField("a.y1",   row, a_y1,         v.y1);
    checkField("a.v0",   row, {7'b0, a_v0}, {7'b0, v.v0});
    checkField("a.v1",   row, {7'b0, a_v1}, {7'b0, v.v1});
    checkField("a.cnt0", row, a_cnt0,       v.c0);
    checkField("a.cnt1", row, a_cnt1,       v.c1);
    checkField("b.y0",   row, {7'b0, b_y0}, {7'b0, v.y0[0]});
    checkField("b.y1",   row, {7'b0, b_y1}, {7'b0, v.y1[0]});
    checkField("b.v0",   row, {7'b0, b_v0}, {7'b0, v.v0});
    checkField("b.v1",   row, {7'b0, b_v1}, {7'b0, v.v1});
    checkField("b.cnt0", row, {6'b0, b_cnt0}, {6'b0, v.bc0});
    checkField("b.cnt1", row, {6'b0, b_cnt1}, {6'b0, v.bc1});
  endtask

  task automatic addVec(input logic r, input logic e, input logic sel,
                        input logic [7:0] data,
                        input logic [7:0] y0, input logic [7:0] y1,
                        input logic v0, input logic v1,
                        input logic [7:0] c0, input logic [7:0] c1,
                        input logic [1:0] bc0, input logic [1:0] bc1);
    vec_t v;
    v.rst = r;  v.en = e;  v.s = sel;  v.d = data;
    v.y0 = y0;  v.y1 = y1; v.v0 = v0;  v.v1 = v1;
    v.c0 = c0;  v.c1 = c1; v.bc0 = bc0; v.bc1 = bc1;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    numChecks = 0;
    numFails  = 0;
    rst = 1'b0;
    en  = 1'b0;
    s   = 1'b0;
    d   = 8'h00;

    //      rst en s  d      y0     y1     v0 v1 c0  c1  bc0 bc1
    // Reset held two cycles with live-looking inputs.
    addVec(1, 1, 1, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 1, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    // Baseline (s,d) = (0,0),(0,1),(1,0),(1,1).
    addVec(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0, 1, 0);
    addVec(0, 1, 0, 8'h01, 8'h01, 8'h00, 1, 0, 2, 0, 2, 0);
    addVec(0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 1, 2, 1, 2, 1);
    addVec(0, 1, 1, 8'h01, 8'h00, 8'h01, 0, 1, 2, 2, 2, 2);
    // Enable gating: nothing routed, counters hold.
    addVec(0, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0, 2, 2, 2, 2);
    // Wide data alternation; dut_b saturates at 3 along the way.
    addVec(0, 1, 0, 8'hA5, 8'hA5, 8'h00, 1, 0, 3, 2, 3, 2);
    addVec(0, 1, 1, 8'h3C, 8'h00, 8'h3C, 0, 1, 3, 3, 3, 3);
    addVec(0, 1, 0, 8'hA5, 8'hA5, 8'h00, 1, 0, 4, 3, 3, 3);
    addVec(0, 1, 1, 8'h3C, 8'h00, 8'h3C, 0, 1, 4, 4, 3, 3);
    // Clear, then five back-to-back words to y0: dut_b counts 1,2,3,3,3.
    addVec(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 0, 8'h01, 8'h01, 8'h00, 1, 0, 1, 0, 1, 0);
    addVec(0, 1, 0, 8'h02, 8'h02, 8'h00, 1, 0, 2, 0, 2, 0);
    addVec(0, 1, 0, 8'h03, 8'h03, 8'h00, 1, 0, 3, 0, 3, 0);
    addVec(0, 1, 0, 8'h04, 8'h04, 8'h00, 1, 0, 4, 0, 3, 0);
    addVec(0, 1, 0, 8'h05, 8'h05, 8'h00, 1, 0, 5, 0, 3, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].s, vecs[i].d);
      checkOutput(i, vecs[i]);
    end

    // Mid-stream reset during a continuous y1 stream: the word on the reset
    // edge is dropped, then the stream resumes counting from 1.
    applyStimulus(0, 1, 1, 8'h11);
    v = '{rst:0, en:1, s:1, d:8'h11, y0:8'h00, y1:8'h11, v0:0, v1:1,
          c0:8'd5, c1:8'd1, bc0:2'd3, bc1:2'd1};
    checkOutput(100, v);

    applyStimulus(0, 1, 1, 8'h22);
    v = '{rst:0, en:1, s:1, d:8'h22, y0:8'h00, y1:8'h22, v0:0, v1:1,
          c0:8'd5, c1:8'd2, bc0:2'd3, bc1:2'd2};
    checkOutput(101, v);

    applyStimulus(1, 1, 1, 8'h33);
    v = '{rst:1, en:1, s:1, d:8'h33, y0:8'h00, y1:8'h00, v0:0, v1:0,
          c0:8'd0, c1:8'd0, bc0:2'd0, bc1:2'd0};
    checkOutput(102, v);

    applyStimulus(0, 1, 1, 8'h44);
    v = '{rst:0, en:1, s:1, d:8'h44, y0:8'h00, y1:8'h44, v0:0, v1:1,
          c0:8'd0, c1:8'd1, bc0:2'd0, bc1:2'd1};
    checkOutput(103, v);

    // Same-cycle select flip after the stream: no dead cycle.
    applyStimulus(0, 1, 0, 8'h55);
    v = '{rst:0, en:1, s:0, d:8'h55, y0:8'h55, y1:8'h00, v0:1, v1:0,
          c0:8'd1, c1:8'd1, bc0:2'd1, bc1:2'd1};
    checkOutput(104, v);

    $display("End of test - %0d assertions evaluated, %0d failures",
             numChecks, numFails);
    $finish;
  end

endmodule
